ras_ctrl: RTL

- Initiator side of the return-address-stack interface in the fetch stage.
- Classifies each accepted fetch using branch-predictor metadata (call, return, speculative branch) and drives the RAS push/pop/new_addr and branch_fetched/branch_retired strobes.
- Counts speculative branches in flight and back-pressures fetch when the RAS index checkpoint FIFO would overflow.
- Suppresses RAS activity around flushes so stack-pointer restoration is never corrupted.

---
 rtl/ras_ctrl_pkg.sv | 18 +
 rtl/ras_ctrl_if.sv | 24 ++
 rtl/ras_ctrl_counter.sv | 39 +++
 rtl/ras_ctrl.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ras_ctrl_pkg.sv
// Shared types and constants for the fetch-side return-address-stack controller.
package ras_ctrl_pkg;

  localparam int unsigned RAS_CTRL_RET_OFFSET = 4;

  typedef enum logic [0:0] {
    RUN,
    RECOVER
  } ras_ctrl_state_t;

  typedef struct packed {
    logic hit;
    logic is_call;
    logic is_return;
    logic is_branch;
  } ras_fetch_meta_t;

endpackage

// File: rtl/ras_ctrl_if.sv
// Strobe bundle from the fetch-side controller to the return-address stack.
interface ras_ctrl_if;
  logic        push;
  logic        pop;
  logic [31:0] new_addr;
  logic        branch_fetched;
  logic        branch_retired;

  modport master (
    output push,
    output pop,
    output new_addr,
    output branch_fetched,
    output branch_retired
  );

  modport slave (
    input push,
    input pop,
    input new_addr,
    input branch_fetched,
    input branch_retired
  );
endinterface

// File: rtl/ras_ctrl_counter.sv
// Up/down counter saturating at 0 and MAX, with a synchronous clear.
module ras_ctrl_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !dec && (count_q != MaxVal)) begin
      count_d = count_q + WIDTH'(1);
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ras_ctrl.sv
// Fetch-side RAS initiator: classifies accepted fetches into push/pop/checkpoint strobes,
// tracks in-flight speculative branches and masks RAS activity around flushes.
module ras_ctrl
  import ras_ctrl_pkg::*;
#(
  parameter int unsigned MAX_IDS     = 8,
  parameter int unsigned RAS_ENTRIES = 8,
  parameter int unsigned INSTR_BYTES = RAS_CTRL_RET_OFFSET
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fetch_flush,
  input  logic                           early_branch_flush,
  input  logic                           fetch_accept,
  input  logic [31:0]                    fetch_pc,
  input  logic                           bp_hit,
  input  logic                           bp_is_call,
  input  logic                           bp_is_return,
  input  logic                           bp_is_branch,
  input  logic                           branch_retire_in,
  ras_ctrl_if.master                     ras,
  output logic                           fetch_stall,
  output logic [$clog2(RAS_ENTRIES):0]   ras_depth_est
);

  localparam int unsigned OutW   = $clog2(MAX_IDS + 1);
  localparam int unsigned DepthW = $clog2(RAS_ENTRIES) + 1;

  ras_ctrl_state_t state_q, state_d;
  ras_fetch_meta_t meta;

  logic            flush;
  logic            run;
  logic            accept_ok;
  logic            at_capacity;
  logic [OutW-1:0] outstanding;

  logic        push_d, pop_d, fetched_d, retired_d;
  logic        push_q, pop_q, fetched_q, retired_q;
  logic [31:0] new_addr_q;

  assign flush = fetch_flush | early_branch_flush;
  assign meta  = '{hit: bp_hit, is_call: bp_is_call, is_return: bp_is_return,
                   is_branch: bp_is_branch};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a flush in either state (re)arms the one-cycle recovery window
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush) state_d = RECOVER;
      RECOVER: state_d = flush ? RECOVER : RUN;
      default: state_d = RUN;
    endcase
  end

  // State-derived output
  always_comb begin
    run = 1'b0;
    unique case (state_q)
      RUN:     run = 1'b1;
      RECOVER: run = 1'b0;
      default: run = 1'b0;
    endcase
  end

  assign at_capacity = (outstanding == OutW'(MAX_IDS));
  assign fetch_stall = !rst && at_capacity;

  // An accept coinciding with a flush belongs to the discarded path
  assign accept_ok = fetch_accept && run && !flush;

  always_comb begin
    push_d    = accept_ok && meta.hit && meta.is_call;
    pop_d     = accept_ok && meta.hit && meta.is_return;
    fetched_d = accept_ok && meta.is_branch && !at_capacity;
    retired_d = run && !flush && branch_retire_in && (outstanding != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      push_q     <= 1'b0;
      pop_q      <= 1'b0;
      fetched_q  <= 1'b0;
      retired_q  <= 1'b0;
      new_addr_q <= '0;
    end else begin
      push_q    <= push_d;
      pop_q     <= pop_d;
      fetched_q <= fetched_d;
      retired_q <= retired_d;
      if (push_d) new_addr_q <= fetch_pc + 32'(INSTR_BYTES);
    end
  end

  assign ras.push           = push_q;
  assign ras.pop            = pop_q;
  assign ras.new_addr       = new_addr_q;
  assign ras.branch_fetched = fetched_q;
  assign ras.branch_retired = retired_q;

  // Cleared on flush to stay aligned with the checkpoint FIFO reset
  ras_ctrl_counter #(
    .WIDTH (OutW),
    .MAX   (MAX_IDS)
  ) u_outstanding (
    .clk   (clk),
    .rst   (rst),
    .clr   (flush),
    .inc   (fetched_d),
    .dec   (retired_d),
    .count (outstanding)
  );

  ras_ctrl_counter #(
    .WIDTH (DepthW),
    .MAX   (RAS_ENTRIES)
  ) u_depth (
    .clk   (clk),
    .rst   (rst),
    .clr   (1'b0),
    .inc   (push_d && !pop_d),
    .dec   (pop_d && !push_d),
    .count (ras_depth_est)
  );

endmodule
